reg_to_apb: RTL

- Register-interface to APB4 bridge. Consumes the regbus emitted by the AXI-to-regbus converter and drives a single APB4 completer port (peripheral subsystem).
- Latches one regbus request, runs the APB SETUP/ACCESS phases and returns a registered response.
- A configurable timeout aborts a hung access with an error, so the upstream AXI path is never blocked indefinitely.

---
 rtl/reg_to_apb.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/reg_to_apb.sv
// -----------------------------------------------------------------------------
// reg_to_apb -- regbus to APB4 bridge
//
// Accepts one regbus request at a time, runs the APB4 SETUP and ACCESS phases
// against a single completer and hands back a registered one-cycle response.
// An optional ACCESS-phase timeout turns a hung completer into an error
// response so the upstream path can always make progress.
//
// Ports
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset
//   reg_req_i  : regbus request  (addr, write, wdata, wstrb, valid)
//   reg_rsp_o  : regbus response (rdata, error, ready), all registered
//   paddr_o    : APB address (latched request address)
//   pprot_o    : APB protection, tied to 3'b000
//   psel_o     : APB select (SETUP and ACCESS)
//   penable_o  : APB enable (ACCESS only)
//   pwrite_o   : APB write
//   pwdata_o   : APB write data
//   pstrb_o    : APB write strobes, forced to zero for reads
//   pready_i   : APB ready
//   prdata_i   : APB read data
//   pslverr_i  : APB slave error
//   busy_o     : high whenever the bridge is not IDLE
// -----------------------------------------------------------------------------

package reg_to_apb_pkg;

    // Default regbus request layout (32-bit address and data).
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    // Default regbus response layout.
    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

module reg_to_apb #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 0,
    parameter type         reg_req_t     = reg_to_apb_pkg::reg_req_t,
    parameter type         reg_rsp_t     = reg_to_apb_pkg::reg_rsp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  reg_req_t               reg_req_i,
    output reg_rsp_t               reg_rsp_o,
    output logic [AddrWidth-1:0]   paddr_o,
    output logic [2:0]             pprot_o,
    output logic                   psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [DataWidth-1:0]   pwdata_o,
    output logic [DataWidth/8-1:0] pstrb_o,
    input  logic                   pready_i,
    input  logic [DataWidth-1:0]   prdata_i,
    input  logic                   pslverr_i,
    output logic                   busy_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    // The counter only has to reach TimeoutCycles-1; keep at least one bit so
    // the logic stays legal when the timeout is disabled.
    localparam int unsigned CntW = (TimeoutCycles > 32'd1) ? $clog2(TimeoutCycles) : 1;

    localparam logic [CntW-1:0] CntLast =
        CntW'((TimeoutCycles > 32'd0) ? (TimeoutCycles - 32'd1) : 32'd0);

    // Reject unsupported data widths at elaboration time.
    if (!((DataWidth == 32'd8) || (DataWidth == 32'd16) || (DataWidth == 32'd32))) begin : g_bad_width
        $error("reg_to_apb: DataWidth must be 8, 16 or 32");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e                 state_q,   state_d;
    logic [AddrWidth-1:0]   addr_q,    addr_d;
    logic                   write_q,   write_d;
    logic [DataWidth-1:0]   wdata_q,   wdata_d;
    logic [StrbWidth-1:0]   strb_q,    strb_d;
    logic                   psel_q,    psel_d;
    logic                   penable_q, penable_d;
    logic                   ready_q,   ready_d;
    logic                   error_q,   error_d;
    logic [DataWidth-1:0]   rdata_q,   rdata_d;
    logic                   busy_q,    busy_d;
    logic [CntW-1:0]        cnt_q,     cnt_d;

    logic                   timeout_hit_s;

    // Abort condition: last permitted ACCESS cycle without pready.
    always_comb begin
        timeout_hit_s = (TimeoutCycles != 32'd0) && (cnt_q == CntLast);
    end

    // Next-state and next-output computation. APB and response outputs are
    // computed for the state being entered so that they come out of flops.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        cnt_d     = cnt_q;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        ready_d   = 1'b0;
        error_d   = 1'b0;
        rdata_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (reg_req_i.valid) begin
                    addr_d  = reg_req_i.addr[AddrWidth-1:0];
                    write_d = reg_req_i.write;
                    wdata_d = reg_req_i.wdata[DataWidth-1:0];
                    // APB4 requires inactive strobes on reads; zero-strobe
                    // writes pass through untouched.
                    if (reg_req_i.write) begin
                        strb_d = reg_req_i.wstrb[StrbWidth-1:0];
                    end else begin
                        strb_d = '0;
                    end
                    psel_d  = 1'b1;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end

            ST_ACCESS: begin
                // pready is checked first so a response on the expiry cycle
                // is taken as a normal completion.
                if (pready_i) begin
                    if (write_q) begin
                        rdata_d = '0;
                    end else begin
                        rdata_d = prdata_i;
                    end
                    error_d = pslverr_i;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else if (timeout_hit_s) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    cnt_d     = cnt_q + CntW'(1'b1);
                    state_d   = ST_ACCESS;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; asynchronous reset clears everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    // Response struct assembled from registered fields.
    always_comb begin
        reg_rsp_o                       = '0;
        reg_rsp_o.rdata[DataWidth-1:0]  = rdata_q;
        reg_rsp_o.error                 = error_q;
        reg_rsp_o.ready                 = ready_q;
    end

    assign paddr_o   = addr_q;
    assign pprot_o   = 3'b000;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = write_q;
    assign pwdata_o  = wdata_q;
    assign pstrb_o   = strb_q;
    assign busy_o    = busy_q;

endmodule
